// File: rtl/gf8_reduce_acc.sv
// gf8_reduce_acc
//   Streaming GF(2^8) reduce-and-accumulate stage. It takes raw 15-bit
//   carry-less products, reduces each one modulo POLY, and XOR-accumulates
//   the reduced bytes of a group. A group is closed by in_last. The group
//   sum and its beat count (saturating at 15) are presented on a
//   valid/ready output register.
//
// Parameters
//   POLY       irreducible reduction polynomial, bit 8 must be set
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   product beat valid
//   in_ready   block accepts a beat this cycle
//   in_prod    carry-less product, bit i = coefficient of x^i
//   in_last    beat closes the current group
//   out_valid  group result held
//   out_ready  consumer takes the result
//   out_data   reduced XOR sum of the group
//   out_count  beats in the group, saturating at 15
//
// Build option
//   GF8_REDUCE_INREG_EN  when defined, a register stage sits in front of
//                        the reduction. Latency goes from 1 edge to 2 edges
//                        and throughput stays at one beat per cycle.
//
// state | meaning
// IDLE  | cnt == 0 and out_valid == 0
// ACCUM | cnt > 0, a partial group is held in acc
// HOLD  | out_valid == 1 and !out_ready; acc/cnt frozen, input stalled
// ACCUM and HOLD can be active at the same time. They are not encoded
// separately; they follow from cnt and out_valid.

module gf8_reduce_acc #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_prod,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  out_count
);

  logic [7:0]  acc;
  logic [3:0]  cnt;
  logic        out_free;
  logic        beat_valid;
  logic        beat_last;
  logic [14:0] beat_prod;
  logic        take;
  logic [7:0]  red;
  logic [7:0]  sum;
  logic [3:0]  cnt_next;

  // The output register can take a new result when it is empty or when it
  // is being drained in this same cycle.
  assign out_free = !out_valid | out_ready;

`ifdef GF8_REDUCE_INREG_EN
  logic        s1_valid;
  logic        s1_last;
  logic [14:0] s1_prod;
  logic        s1_advance;

  assign s1_advance = s1_valid & out_free;
  assign in_ready   = !s1_valid | s1_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (in_valid & in_ready) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_prod  <= in_prod;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  assign beat_valid = s1_valid;
  assign beat_last  = s1_last;
  assign beat_prod  = s1_prod;
`else
  assign in_ready   = out_free;
  assign beat_valid = in_valid;
  assign beat_last  = in_last;
  assign beat_prod  = in_prod;
`endif

  assign take = beat_valid & out_free;

  // Long division by POLY, from the top coefficient down. Each set bit at
  // x^i (i >= 8) is cancelled by XORing POLY shifted up by i-8.
  function automatic logic [7:0] gf_reduce(input logic [14:0] p);
    logic [14:0] r;
    r = p;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ ({6'b0, POLY} << (i - 8));
    end
    return r[7:0];
  endfunction

  always_comb begin
    red      = gf_reduce(beat_prod);
    sum      = acc ^ red;
    cnt_next = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (take) begin
        if (beat_last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt_next;
        end
      end

      // A closing beat reloads the output register even while the previous
      // result drains, so back-to-back groups have no bubble.
      if (take & beat_last) begin
        out_data  <= sum;
        out_count <= cnt_next;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gf8_reduce_acc.md
# gf8_reduce_acc

Streaming GF(2^8) reduce-and-accumulate stage sitting directly downstream of the 8x8 carry-less (polynomial) multiplier. It accepts the raw 15-bit carry-less product and reduces it modulo a fixed irreducible polynomial. It XOR-accumulates the reduced bytes of a group of products delimited by `in_last`, then presents the group sum on a valid/ready output port. Typical use: GF(2^8) dot products and MAC chains.

## Interface
- `POLY`, 9'h11B, irreducible reduction polynomial; bit 8 must be 1 (x^8+x^4+x^3+x+1 default).
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous active-low reset.
- `in_valid` input 1 — product beat valid.
- `in_ready` output 1 — block accepts beat this cycle.
- `in_prod` input 15 — carry-less product, bit i = coefficient of x^i.
- `in_last` input 1 — beat closes the current group.
- `out_valid` output 1 — group result held.
- `out_ready` input 1 — consumer takes result.
- `out_data` output 8 — reduced XOR sum of the group.
- `out_count` output 4 — number of beats in group, saturating at 15.

## Operation
- Reduction (combinational): r = in_prod; for i = 14 down to 8: if r[i], r ^= POLY << (i-8); result = r[7:0].
- Registers: `acc[7:0]`, `cnt[3:0]`, output register (`out_data`, `out_count`, `out_valid`).
- Accept = `in_valid & in_ready`. `in_ready = !out_valid | out_ready` (output register free or being drained this cycle).
- On accept, not last: acc <= acc ^ red; cnt <= sat15(cnt+1).
- On accept with `in_last`: out_data <= acc ^ red; out_count <= sat15(cnt+1); out_valid <= 1; acc <= 0; cnt <= 0.
- Output handshake: `out_valid & out_ready` with no new last-beat clears out_valid; a new last-beat in the same cycle reloads the register (back-to-back groups, no bubble).
- States: IDLE (cnt=0, out_valid=0); ACCUM (cnt>0); HOLD (out_valid=1 and !out_ready). In HOLD, in_ready=0 and acc/cnt are frozen. ACCUM and HOLD may coexist (acc holds a partial group while a result waits).
- A single-beat group (in_last on first beat) yields out_count=1.
- in_prod bits are never masked; any 15-bit value is legal.
- `out_data`/`out_count` hold stable while out_valid=1 and !out_ready.

## Timing
- Reset (async assert, synchronous deassert release by clk): acc=0, cnt=0, out_valid=0, out_data=0, out_count=0; in_ready=1 on first cycle after reset.
- Latency without input register: last beat accepted on edge N -> out_valid=1 from edge N.
- Throughput: one beat per cycle while the output is drained every cycle.
- Reset mid-group discards the partial accumulation and any held result.
- Critical path: 7-level reduction XOR tree + 8-bit XOR into acc.

## Configuration
- `GF8_REDUCE_INREG_EN` defined: a registered input stage (`in_prod`, `in_last`, valid bit) precedes reduction. `in_ready = !s1_valid | s1_advance`. Latency from acceptance to out_valid becomes 2 edges; throughput is unchanged; the stage register resets to invalid.
- Undefined: reduction is fed directly from the inputs, with 1-edge latency.

## Test plan
- Reduction vectors, single-beat groups, out_ready=1: in_prod 0x0100 -> out_data 0x1B; 0x4000 -> 0x9A; 0x3F7E (0x53·0xCA) -> 0x01; 0x00FF -> 0xFF; out_count=1 each.
- Group accumulate: beats 0x0100, 0x0001, 0x3F7E (last) -> out_data 0x1B, out_count 3, acc/cnt return to 0.
- Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable for 5 cycles. A pending partial group is preserved. Release -> next group result correct.
- Back-to-back: last-beat every cycle with out_ready=1 -> one result per cycle, no dropped or duplicated beats; compare against a scoreboard.
- Saturation: 20-beat group of 0x0001 -> out_data 0x00, out_count 15.
- Reset mid-group: 2 beats accepted, assert rst_n low asynchronously -> all outputs 0 immediately. The next group of 0x0002 (last) -> 0x02, count 1. Repeat all scenarios with `GF8_REDUCE_INREG_EN` defined, expecting +1 edge latency.
